ex_hazard_fwd_ctrl: RTL and testbench
=====================================

Name: ex_hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline. It sits between the ID stage and EX.
- It tracks destination-register info for the instructions in the ID/EX and EX/MEM slots. From that it produces registered 2-bit selects for the EX-stage operand forwarding muxes (rs1 path, rs2 path).
- It detects load-use hazards, holds PC and IF/ID, and injects a bubble into ID/EX.
- It keeps a load-use stall performance counter.

Parameters:
- REG_ADDR_W, 5, register-index width
- CNT_W, 32, stall counter width

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID-stage instruction is valid
- id_rs1  input  REG_ADDR_W  ID source register 1
- id_rs2  input  REG_ADDR_W  ID source register 2
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_ADDR_W  ID destination register
- id_regwrite  input  1  instruction writes rd
- id_memread  input  1  instruction is a load
- ex_flush  input  1  taken branch/jump resolved in EX; kill ID instruction
- stall_out  output  1  hold PC and IF/ID this cycle (combinational)
- idex_bubble  output  1  ID/EX loads a NOP at this edge (combinational)
- forward_a  output  2  registered rs1 select for the EX instruction
- forward_b  output  2  registered rs2 select for the EX instruction
- stall_count  output  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Select encoding matches the EX mux:
  - 00 = ID/EX register-file value
  - 01 = MEM/WB writeback data
  - 10 = EX/MEM ALU result
  - 11 is never driven.
- Internal slots:
  - E (tracks ID/EX) and M (tracks EX/MEM), each holding {valid, rd, regwrite, memread}.
- Reset, synchronous, at posedge with rst=1:
  - E.valid=0, M.valid=0.
  - forward_a=forward_b=00, stall_count=0.
  - stall_out/idex_bubble follow from invalid slots, so both are 0 in the cycle after reset.
  - A reset during a stall cancels it.
- hazard (combinational) is true when all of the following hold:
  - id_valid, E.valid, E.memread, E.rd≠0;
  - and either (id_use_rs1 and id_rs1==E.rd) or (id_use_rs2 and id_rs2==E.rd).
- Output equations:
  - stall_out = hazard and not ex_flush.
  - idex_bubble = hazard or ex_flush.
- Every clock edge, when not in reset:
  - M ← E.
  - E ← invalid if (idex_bubble or !id_valid); otherwise E ← ID fields.
- Forward select for operand X (rs1→forward_a, rs2→forward_b), registered at the same edge E loads:
  - If idex_bubble or !id_valid or !id_use_X or id_rsX==0 → 00.
  - Else if E.valid, E.regwrite, E.rd==id_rsX → 10. E becomes EX/MEM next cycle; the newest producer wins.
  - Else if M.valid, M.regwrite, M.rd==id_rsX → 01.
  - Else 00.
- A load in E that matches is always caught as a hazard, so 10 never selects a load result.
- After a 1-cycle stall the load sits in M, and the held ID instruction gets 01.
- Register x0 is never forwarded and never causes a stall.
- ex_flush has priority over hazard:
  - No stall, bubble inserted.
  - Slot M still advances from E; only the ID instruction is killed.
- stall_count increments by 1 on each edge with stall_out=1 and saturates at all-ones.
- Latency:
  - forward_a/forward_b are valid in the same cycle the instruction occupies EX. Zero added pipeline latency.
  - stall_out/idex_bubble are same-cycle combinational.
- Out of scope: regfile write-through for the WB→ID distance. The regfile is write-first.

Test Plan:
- ALU back-to-back: add x5 followed by sub x6,x5,x7 → in sub's EX cycle forward_a=10, forward_b=00, no stall.
- Distance 2: add x5, nop, or x8,x9,x5 → forward_b=01 for or; add x5 then add x5,x5 again with a consumer → newest wins, select 10.
- Load-use: lw x4 then add x1,x4,x4 → stall_out=1 and idex_bubble=1 for exactly 1 cycle; stall_count 0→1; add then enters EX with forward_a=forward_b=01.
- x0: lw x0 then add x1,x0,x0 → no stall, selects 00; id_use_rs2=0 with a matching rs2 → forward_b=00.
- Flush during hazard: lw x4, add x1,x4,x2 with ex_flush=1 → stall_out=0, idex_bubble=1, next-cycle E invalid, stall_count unchanged.
- Reset mid-stall: assert rst in the hazard cycle → next cycle forward_*=00, stall_out=0, stall_count=0; also force stall_count to all-ones then stall again → stays all-ones.

Source files
------------

// File: rtl/ex_hazard_fwd_ctrl.sv
// ex_hazard_fwd_ctrl
// Hazard detection and operand-forwarding control for a 5-stage RISC-V pipe.
// It tracks the destination info of the instructions in ID/EX (slot E) and
// EX/MEM (slot M). From that it produces:
//   - registered forward selects for the EX operand muxes (rs1 -> forward_a,
//     rs2 -> forward_b), and
//   - combinational stall/bubble controls for load-use hazards and flushes.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   id_*              decoded fields of the instruction currently in ID
//   ex_flush          taken branch/jump in EX; kills the ID instruction
//   stall_out         hold PC and IF/ID this cycle
//   idex_bubble       ID/EX captures a NOP at the coming edge
//   forward_a/b       EX mux selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_count       saturating count of load-use stall cycles
module ex_hazard_fwd_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  ex_flush,
   output logic                  stall_out,
   output logic                  idex_bubble,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic [CNT_W-1:0]      stall_count
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } slot_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   slot_t e_q, m_q, e_nxt;
   logic  hazard;
   logic  e_load_rs1, e_load_rs2;

   // Two operand lanes share one select rule; lane 0 is rs1, lane 1 is rs2.
   logic [1:0][REG_ADDR_W-1:0] src;
   logic [1:0]                 use_src;
   logic [1:0][1:0]            fwd_nxt, fwd_q;

   assign src     = {id_rs2, id_rs1};
   assign use_src = {id_use_rs2, id_use_rs1};

   // A load still in E cannot feed the ID instruction yet; x0 never stalls.
   assign e_load_rs1 = id_use_rs1 && (id_rs1 == e_q.rd);
   assign e_load_rs2 = id_use_rs2 && (id_rs2 == e_q.rd);
   assign hazard     = id_valid && e_q.valid && e_q.memread && (e_q.rd != '0)
                       && (e_load_rs1 || e_load_rs2);

   // Flush wins: the ID instruction is dead, so there is nothing to hold.
   assign stall_out   = hazard && !ex_flush;
   assign idex_bubble = hazard || ex_flush;

   always_comb begin
      e_nxt = '0;
      if (!idex_bubble && id_valid) begin
         e_nxt.valid    = 1'b1;
         e_nxt.rd       = id_rd;
         e_nxt.regwrite = id_regwrite;
         e_nxt.memread  = id_memread;
      end
   end

   // Selects are computed against the slots as they will look once the ID
   // instruction reaches EX: today's E becomes EX/MEM, today's M becomes
   // MEM/WB. Checking E first makes the newest producer win.
   for (genvar op = 0; op < 2; op++) begin : g_fwd
      always_comb begin
         fwd_nxt[op] = FWD_RF;
         if (idex_bubble || !id_valid || !use_src[op] || (src[op] == '0))
            fwd_nxt[op] = FWD_RF;
         else if (e_q.valid && e_q.regwrite && (e_q.rd == src[op]))
            fwd_nxt[op] = FWD_MEM;
         else if (m_q.valid && m_q.regwrite && (m_q.rd == src[op]))
            fwd_nxt[op] = FWD_WB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q         <= '0;
         m_q         <= '0;
         fwd_q       <= '0;
         stall_count <= '0;
      end else begin
         m_q   <= e_q;
         e_q   <= e_nxt;
         fwd_q <= fwd_nxt;
         if (stall_out && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   assign forward_a = fwd_q[0];
   assign forward_b = fwd_q[1];

endmodule

// File: tb/tb_ex_hazard_fwd_ctrl.sv
// Directed test for ex_hazard_fwd_ctrl. A narrow stall counter (CNT_W=3)
// keeps the saturation case short.
module tb_ex_hazard_fwd_ctrl;
   localparam int RW = 5;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic [RW-1:0] id_rs1, id_rs2, id_rd;
   logic          ex_flush;
   logic          stall_out, idex_bubble;
   logic [1:0]    forward_a, forward_b;
   logic [CW-1:0] stall_count;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ex_hazard_fwd_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_flush(ex_flush),
      .stall_out(stall_out), .idex_bubble(idex_bubble),
      .forward_a(forward_a), .forward_b(forward_b),
      .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one ID instruction; settles before the next rising edge.
   task automatic id_set(input logic v, input int rs1, input logic u1,
                         input int rs2, input logic u2, input int rd,
                         input logic rw, input logic mr, input logic fl);
      @(negedge clk);
      id_valid = v; id_rs1 = RW'(rs1); id_use_rs1 = u1;
      id_rs2 = RW'(rs2); id_use_rs2 = u2; id_rd = RW'(rd);
      id_regwrite = rw; id_memread = mr; ex_flush = fl;
      #1;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      edge_step();
      edge_step();
      rst = 1'b0;
      chk("rst_fa", forward_a, 0);
      chk("rst_fb", forward_b, 0);
      chk("rst_cnt", stall_count, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_bubble", idex_bubble, 0);

      // add x5,x1,x2 ; sub x6,x5,x7
      id_set(1, 1, 1, 2, 1, 5, 1, 0, 0); edge_step();
      id_set(1, 5, 1, 7, 1, 6, 1, 0, 0);
      chk("b2b_stall", stall_out, 0);
      edge_step();
      chk("b2b_fa", forward_a, 2);
      chk("b2b_fb", forward_b, 0);

      // add x5 ; nop ; or x8,x9,x5
      id_set(1, 1, 1, 2, 1, 5, 1, 0, 0); edge_step();
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); edge_step();
      id_set(1, 9, 1, 5, 1, 8, 1, 0, 0); edge_step();
      chk("d2_fa", forward_a, 0);
      chk("d2_fb", forward_b, 1);

      // add x5 ; add x5,x5,x5 ; add x10,x5,x0 -- newest producer wins
      id_set(1, 1, 1, 1, 1, 5, 1, 0, 0); edge_step();
      id_set(1, 5, 1, 5, 1, 5, 1, 0, 0); edge_step();
      chk("new_fa", forward_a, 2);
      chk("new_fb", forward_b, 2);
      id_set(1, 5, 1, 0, 1, 10, 1, 0, 0); edge_step();
      chk("new2_fa", forward_a, 2);
      chk("x0_fb", forward_b, 0);

      // lw x4 ; add x1,x4,x4 -- one stall cycle then MEM/WB forwarding
      id_set(1, 1, 1, 0, 0, 4, 1, 1, 0); edge_step();
      id_set(1, 4, 1, 4, 1, 1, 1, 0, 0);
      chk("lu_stall", stall_out, 1);
      chk("lu_bubble", idex_bubble, 1);
      chk("lu_cnt0", stall_count, 0);
      edge_step();
      chk("lu_stall2", stall_out, 0);
      chk("lu_bubble2", idex_bubble, 0);
      chk("lu_cnt1", stall_count, 1);
      chk("lu_bub_fa", forward_a, 0);
      edge_step();
      chk("lu_fa", forward_a, 1);
      chk("lu_fb", forward_b, 1);

      // lw x0 ; add x1,x0,x0 -- x0 neither stalls nor forwards
      id_set(1, 1, 1, 0, 0, 0, 1, 1, 0); edge_step();
      id_set(1, 0, 1, 0, 1, 1, 1, 0, 0);
      chk("x0_stall", stall_out, 0);
      edge_step();
      chk("x0_fa", forward_a, 0);
      chk("x0_fb2", forward_b, 0);

      // add x2 ; consumer with matching rs2 but id_use_rs2=0
      id_set(1, 1, 1, 1, 1, 2, 1, 0, 0); edge_step();
      id_set(1, 9, 1, 2, 0, 3, 1, 0, 0); edge_step();
      chk("nouse_fb", forward_b, 0);
      chk("nouse_fa", forward_a, 0);

      // lw x4 ; add x1,x4,x2 with ex_flush -- bubble, no stall
      id_set(1, 1, 1, 0, 0, 4, 1, 1, 0); edge_step();
      id_set(1, 4, 1, 2, 1, 1, 1, 0, 1);
      chk("fl_stall", stall_out, 0);
      chk("fl_bubble", idex_bubble, 1);
      edge_step();
      chk("fl_cnt", stall_count, 1);
      // E is now empty, so this consumer of x4 does not stall; load is in M.
      id_set(1, 4, 1, 0, 0, 7, 1, 0, 0);
      chk("fl_e_empty", stall_out, 0);
      edge_step();
      chk("fl_fa", forward_a, 1);

      // Reset asserted in the hazard cycle
      id_set(1, 1, 1, 0, 0, 4, 1, 1, 0); edge_step();
      id_set(1, 4, 1, 4, 1, 1, 1, 0, 0);
      chk("rs_pre_stall", stall_out, 1);
      rst = 1'b1;
      edge_step();
      rst = 1'b0;
      chk("rs_fa", forward_a, 0);
      chk("rs_fb", forward_b, 0);
      chk("rs_stall", stall_out, 0);
      chk("rs_cnt", stall_count, 0);

      // Saturation of the 3-bit counter: 8 load-use stalls leave it at 7
      for (int i = 0; i < 8; i++) begin
         id_set(1, 1, 1, 0, 0, 4, 1, 1, 0); edge_step();
         id_set(1, 4, 1, 4, 1, 1, 1, 0, 0);
         if (stall_out !== 1'b1) chk("sat_stall", stall_out, 1);
         edge_step();
         if (i == 6) chk("sat_cnt7", stall_count, 7);
      end
      chk("sat_hold", stall_count, 7);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
